instruction_fetch_unit: RTL

//  Requester side of the instruction memory interface. Holds the PC and drives the word address into the combinational

---
 rtl/instruction_fetch_unit_pkg.sv | 17 +
 rtl/instruction_fetch_unit_if.sv | 29 ++
 rtl/instruction_fetch_unit_pc_reg.sv | 37 +++
 rtl/instruction_fetch_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared constants, FSM encodings and PC alignment helper for the fetch unit
package instruction_fetch_unit_pkg;

    localparam logic [31:0] INSTR_NOP    = 32'h00000013;
    localparam logic [31:0] INSTR_EBREAK = 32'h00100073;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] PC_ALIGN     = 32'hFFFF_FFFC;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & PC_ALIGN;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory port and IF/ID handshake bundle
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_instr;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_pc;
    logic [31:0]       if_instr;

    modport master (
        output imem_addr,
        input  imem_instr,
        output if_valid,
        input  if_ready,
        output if_pc,
        output if_instr
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  if_valid,
        output if_ready,
        input  if_pc,
        input  if_instr
    );
endinterface

// File: rtl/instruction_fetch_unit_pc_reg.sv
// rtl/instruction_fetch_unit_pc_reg.sv - fetch_pc_reg: program counter with +4 step and aligned redirect
module fetch_pc_reg
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q, pc_d;

    // Redirect wins over a step; the top never asserts both in one cycle anyway.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = align_pc(redirect_pc_i);
        end else if (advance_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, instruction memory request and IF/ID output register with valid/ready
// Optional FETCH_HALT_EN: stop fetching after delivering an EBREAK until the next redirect.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic                        clk,
    input  logic                        reset,
    instruction_fetch_unit_if.master    bus,
    input  logic                        stall,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_pc,
    output logic [31:0]                 fetch_count,
    output logic                        halted
);

    logic [1:0]  state_q, state_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc;
    logic        consume;
    logic        load;

    assign consume = if_valid_q & bus.if_ready;
    assign load    = (state_q == ST_RUN) & ~stall & (~if_valid_q | bus.if_ready) & ~redirect_valid;

    fetch_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk              (clk),
        .reset            (reset),
        .advance_i        (load),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .pc_o             (pc)
    );

    assign bus.imem_addr = pc[ADDR_W+1:2];

`ifdef FETCH_HALT_EN
    logic halted_q, halted_d;

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                // The EBREAK itself is still loaded; only later fetches stop.
                if (load && (bus.imem_instr == INSTR_EBREAK)) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    state_d  = ST_RUN;
                    halted_d = 1'b0;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;
`else
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    assign halted = 1'b0;
`endif

    // A consume coinciding with a redirect still counts: decode took that word.
    always_comb begin
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        count_d    = count_q + {31'd0, consume};
        if (redirect_valid) begin
            if_valid_d = 1'b0;
        end else if (load) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc;
            if_instr_d = bus.imem_instr;
        end else if (consume) begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'd0;
            if_instr_q <= INSTR_NOP;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            count_q    <= count_d;
        end
    end

    assign bus.if_valid = if_valid_q;
    assign bus.if_pc    = if_pc_q;
    assign bus.if_instr = if_instr_q;
    assign fetch_count  = count_q;

endmodule
